// File: rtl/vc_test_rand_check_sink.sv
// Self-checking val/rdy sink: applies LFSR-driven random backpressure and compares
// each accepted message, in order, against a loadable expected-message array.
module vc_test_rand_check_sink #(
    parameter int          p_msg_nbits = 8,
    parameter int          p_max_msgs  = 1024,
    parameter logic [15:0] p_seed      = 16'hACE1,
    localparam int         p_idx_nbits = $clog2(p_max_msgs)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             max_delay,
    input  logic [p_idx_nbits:0]   num_msgs,
    input  logic                   load_en,
    input  logic [p_idx_nbits-1:0] load_addr,
    input  logic [p_msg_nbits-1:0] load_msg,
    input  logic                   val,
    output logic                   rdy,
    input  logic [p_msg_nbits-1:0] msg,
    output logic                   done,
    output logic [15:0]            err_count,
    output logic [p_idx_nbits:0]   first_err_idx,
    output logic                   overflow
);

    typedef enum logic [1:0] {
        S_DRAW,
        S_WAIT,
        S_READY,
        S_DONE
    } state_t;

    state_t                 state, state_next;
    logic [7:0]             cnt, cnt_next;
    logic [p_idx_nbits:0]   idx, idx_next, idx_inc;
    logic [15:0]            lfsr;
    logic                   lfsr_fb;
    logic [7:0]             draw;
    logic                   xfer;
    logic                   mismatch;
    logic                   rec_err;
    logic                   rec_ovf;
    logic [p_msg_nbits-1:0] exp_mem [p_max_msgs];
    logic [p_msg_nbits-1:0] exp_cur;

    // Fibonacci taps 16,14,13,11; draw is the next gap length, 0..max_delay.
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign draw    = 8'({1'b0, lfsr[7:0]} % ({1'b0, max_delay} + 9'd1));

    assign rdy      = reset_n && ((state == S_READY) || (state == S_DONE));
    assign xfer     = val && rdy;
    assign exp_cur  = exp_mem[idx[p_idx_nbits-1:0]];
    assign mismatch = (msg != exp_cur);
    assign idx_inc  = idx + (p_idx_nbits + 1)'(1);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        rec_err    = 1'b0;
        rec_ovf    = 1'b0;
        case (state)
            S_DRAW: begin
                if (num_msgs == '0) begin
                    state_next = S_DONE;
                end else if (draw == 8'd0) begin
                    state_next = S_READY;
                end else begin
                    state_next = S_WAIT;
                    cnt_next   = draw;
                end
            end
            S_WAIT: begin
                cnt_next = cnt - 8'd1;
                if (cnt == 8'd1) state_next = S_READY;
            end
            S_READY: begin
                if (xfer) begin
                    rec_err  = mismatch;
                    idx_next = idx_inc;
                    if (idx_inc == num_msgs) begin
                        state_next = S_DONE;
                    end else if (draw != 8'd0) begin
                        state_next = S_WAIT;
                        cnt_next   = draw;
                    end
                end
            end
            S_DONE: begin
                rec_ovf = xfer;
            end
            default: state_next = S_DRAW;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_DRAW;
            cnt           <= '0;
            idx           <= '0;
            lfsr          <= p_seed;
            done          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '1;
            overflow      <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            lfsr  <= {lfsr[14:0], lfsr_fb};
            done  <= (state_next == S_DONE);
            if ((rec_err || rec_ovf) && (err_count != 16'hFFFF))
                err_count <= err_count + 16'd1;
            if (rec_err && (first_err_idx == '1))
                first_err_idx <= idx;
            if (rec_ovf)
                overflow <= 1'b1;
        end
    end

    // NOTE: the expected array is deliberately not reset so it can be loaded during reset.
    always_ff @(posedge clk) begin
        if (load_en) exp_mem[load_addr] <= load_msg;
    end

endmodule

// File: tb/tb_vc_test_rand_check_sink.sv
// Randomized scoreboard bench for vc_test_rand_check_sink: stimulus queues expected
// results, a monitor tracks rdy timing against an LFSR gap model and checks outputs.
module tb_vc_test_rand_check_sink;

    localparam int          IDX  = 10;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          BIG  = 1 << 30;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [7:0]     max_delay;
    logic [IDX:0]   num_msgs;
    logic           load_en;
    logic [IDX-1:0] load_addr;
    logic [7:0]     load_msg;
    logic           val;
    logic           rdy;
    logic [7:0]     msg;
    logic           done;
    logic [15:0]    err_count;
    logic [IDX:0]   first_err_idx;
    logic           overflow;

    vc_test_rand_check_sink dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .max_delay     (max_delay),
        .num_msgs      (num_msgs),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_msg      (load_msg),
        .val           (val),
        .rdy           (rdy),
        .msg           (msg),
        .done          (done),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]  err;
        logic [IDX:0] first;
        logic         ovf;
        logic         done;
    } resp_t;

    resp_t      sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    logic [7:0] ref_mem [16];

    // Stimulus-side reference of the error bookkeeping for the current run.
    int s_n, s_idx, s_err, s_first;
    bit s_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic finish_bench();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        int  taps [4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        foreach (taps[i]) fb ^= l[taps[i]-1];
        return {l[14:0], fb};
    endfunction

    function automatic int gap(input logic [15:0] l, input int md);
        return int'(l[7:0]) % (md + 1);
    endfunction

    // Monitor: k counts cycles since the last reset edge; rdy is expected from
    // cycle ready_at (or forever from done_from once all messages are consumed).
    bit         m_valid = 0;
    int         m_k, m_nx, m_ready_at, m_done_from;
    logic [15:0] m_lf;
    bit         m_exp_rdy;
    resp_t      m_r;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                @(posedge clk);
                m_valid = 1; m_k = 0; m_nx = 0; m_lf = SEED;
                m_ready_at = BIG; m_done_from = BIG;
                continue;
            end
            if (!m_valid) begin
                @(posedge clk);
                continue;
            end
            if (m_k == 0) begin
                if (num_msgs == 0) m_done_from = 1;
                else               m_ready_at  = 1 + gap(m_lf, int'(max_delay));
            end
            m_exp_rdy = (m_k >= m_done_from) || (m_k >= m_ready_at);
            check("rdy", rdy, m_exp_rdy);
            check("done", done, m_k >= m_done_from);
            if (m_exp_rdy && val) begin
                if (m_k < m_done_from) begin
                    m_nx++;
                    if (m_nx == int'(num_msgs)) begin
                        m_done_from = m_k + 1;
                        m_ready_at  = BIG;
                    end else begin
                        m_ready_at = m_k + 1 + gap(m_lf, int'(max_delay));
                    end
                end
                @(posedge clk);
                #1;
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_xfer: got transfer, expected none (t=%0t)", $time);
                end else begin
                    m_r = sb.pop_front();
                    check("err_count", err_count, m_r.err);
                    check("first_err_idx", first_err_idx, m_r.first);
                    check("overflow", overflow, m_r.ovf);
                    check("done_after_xfer", done, m_r.done);
                end
            end else begin
                @(posedge clk);
            end
            m_lf = lfsr_step(m_lf);
            m_k++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input int addr, input logic [7:0] data);
        load_en   = 1'b1;
        load_addr = IDX'(addr);
        load_msg  = data;
        ref_mem[addr] = data;
        tick(1);
        load_en = 1'b0;
    endtask

    task automatic start_run(input int n, input int md);
        val       = 1'b0;
        num_msgs  = (IDX + 1)'(n);
        max_delay = 8'(md);
        reset_n   = 1'b0;
        sb.delete();
        tick(1);
        reset_n = 1'b1;
        s_n = n; s_idx = 0; s_err = 0; s_first = -1; s_ovf = 0;
    endtask

    task automatic send(input logic [7:0] m, input bit idles);
        resp_t r;
        int    w;
        if (idles && $urandom_range(3) == 0) begin
            val = 1'b0;
            tick($urandom_range(3, 1));
        end
        if (s_idx < s_n) begin
            if (m !== ref_mem[s_idx]) begin
                if (s_err < 65535) s_err++;
                if (s_first < 0) s_first = s_idx;
            end
            s_idx++;
            r.done = (s_idx == s_n);
        end else begin
            s_ovf = 1;
            if (s_err < 65535) s_err++;
            r.done = 1'b1;
        end
        r.ovf   = s_ovf;
        r.err   = 16'(s_err);
        r.first = (s_first < 0) ? '1 : (IDX + 1)'(s_first);
        sb.push_back(r);
        msg = m;
        val = 1'b1;
        w = 0;
        forever begin
            @(negedge clk);
            if (rdy) begin
                tick(1);
                break;
            end
            tick(1);
            w++;
            if (w > 300) begin
                vectors++;
                miscompares++;
                $display("FAIL xfer_timeout: got no rdy in 300 cycles, expected a transfer (t=%0t)", $time);
                finish_bench();
            end
        end
    endtask

    int t0;
    int md;

    initial begin
        reset_n   = 1'b0;
        val       = 1'b0;
        msg       = '0;
        load_en   = 1'b0;
        load_addr = '0;
        load_msg  = '0;
        max_delay = '0;
        num_msgs  = '0;
        tick(2);
        for (int i = 0; i < 16; i++) load(i, 8'(i));

        // Empty run: done on the second cycle, nothing counted.
        start_run(0, 5);
        tick(4);
        check("t1_err", err_count, 0);
        check("t1_first", first_err_idx, 11'h7FF);
        check("t1_done", done, 1);
        check("t1_rdy", rdy, 1);

        // One message per cycle with max_delay = 0.
        start_run(16, 0);
        t0 = cyc;
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
        val = 1'b0;
        check("t2_cycles", cyc - t0, 17);
        tick(2);
        check("t2_done", done, 1);
        check("t2_err", err_count, 0);

        // Random gaps up to 10, then three overflow messages.
        start_run(16, 10);
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
        for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0);
        val = 1'b0;
        tick(2);
        check("t3_ovf", overflow, 1);
        check("t3_err", err_count, 3);
        check("t3_rdy", rdy, 1);

        // Two corrupted messages with idle upstream cycles.
        start_run(16, $urandom_range(6, 1));
        for (int i = 0; i < 16; i++)
            send((i == 5) ? 8'hFF : (i == 9) ? 8'hEE : 8'(i), 1'b1);
        val = 1'b0;
        tick(2);
        check("t4_err", err_count, 2);
        check("t4_first", first_err_idx, 5);
        check("t4_done", done, 1);

        // Abort after 7 transfers (one bad), then a clean full rerun.
        start_run(16, 4);
        for (int i = 0; i < 7; i++) send((i == 2) ? 8'hAA : 8'(i), 1'b1);
        val = 1'b0;
        check("t5_err_mid", err_count, 1);
        start_run(16, 4);
        for (int i = 0; i < 16; i++) send(8'(i), 1'b1);
        val = 1'b0;
        tick(2);
        check("t5_err", err_count, 0);
        check("t5_first", first_err_idx, 11'h7FF);
        check("t5_done", done, 1);
        check("t5_ovf", overflow, 0);

        // Random delay bounds and random corruption.
        repeat (3) begin
            md = $urandom_range(15);
            start_run(16, md);
            for (int i = 0; i < 16; i++)
                send(($urandom_range(3) == 0) ? 8'($urandom) : 8'(i), 1'b1);
            val = 1'b0;
            tick(3);
        end

        finish_bench();
    end

endmodule
